// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (fetch / data) arbiter onto a single-outstanding
//            memory port. Fixed priority with a starvation guard by default;
//            define MEM_ARB_RR_EN for round-robin arbitration instead.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    input  logic        d_read_i,
    input  logic        d_write_i,
    input  logic [3:0]  d_strb_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_strb_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } state_t;

    state_t r_state;
    logic   r_owner_fetch;
    logic   w_d_req;
    logic   w_fetch_wins;
    logic   w_grant_ok;

    assign w_d_req = d_read_i | d_write_i;

`ifdef MEM_ARB_RR_EN
    logic r_rr_fetch;

    assign w_fetch_wins = if_req_i & (~w_d_req | r_rr_fetch);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_fetch <= 1'b0;
        end else if (if_gnt_o || d_gnt_o) begin
            r_rr_fetch <= ~r_rr_fetch;
        end
    end
`else
    localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_starve_cnt;

    assign w_fetch_wins = if_req_i & (~w_d_req | (r_starve_cnt == c_LIMIT));

    // Counts data grants that bypassed a waiting fetch; saturates at the limit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_starve_cnt <= '0;
        end else if (if_gnt_o) begin
            r_starve_cnt <= '0;
        end else if (d_gnt_o && if_req_i && (r_starve_cnt != c_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
        end
    end
`endif

    // Grants are decoded in the request cycle so the requester can drop it next cycle.
    assign w_grant_ok = rst_ni & (r_state == ST_IDLE);
    assign if_gnt_o   = w_grant_ok & w_fetch_wins;
    assign d_gnt_o    = w_grant_ok & w_d_req & ~w_fetch_wins;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_owner_fetch <= 1'b0;
            if_rvalid_o   <= 1'b0;
            d_rvalid_o    <= 1'b0;
            rdata_o       <= '0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_strb_o    <= '0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            d_rvalid_o  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (if_gnt_o) begin
                        r_owner_fetch <= 1'b1;
                        mem_req_o     <= 1'b1;
                        mem_we_o      <= 1'b0;
                        mem_strb_o    <= 4'b1111;
                        mem_addr_o    <= if_addr_i;
                        mem_wdata_o   <= '0;
                        r_state       <= ST_REQ;
                    end else if (d_gnt_o) begin
                        // A simultaneous read and write is treated as a store.
                        r_owner_fetch <= 1'b0;
                        mem_req_o     <= 1'b1;
                        mem_we_o      <= d_write_i;
                        mem_strb_o    <= d_write_i ? d_strb_i : 4'b1111;
                        mem_addr_o    <= d_addr_i;
                        mem_wdata_o   <= d_wdata_i;
                        r_state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (mem_we_o) begin
                            d_rvalid_o <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_R;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (mem_rvalid_i) begin
                        rdata_o     <= mem_rdata_i;
                        if_rvalid_o <= r_owner_fetch;
                        d_rvalid_o  <= ~r_owner_fetch;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while fetch waits (fixed-priority mode only).
REQ-002 SHALL have clk_i  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have rst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have if_req_i  input  1  fetch read request; held until if_gnt_o.
REQ-005 SHALL have if_addr_i  input  32  fetch word address.
REQ-006 SHALL have if_gnt_o  output  1  one-cycle pulse: fetch request captured.
REQ-007 SHALL have if_rvalid_o  output  1  one-cycle pulse: rdata_o holds fetch data.
REQ-008 SHALL have d_read_i  input  1  exec-stage load request.
REQ-009 SHALL have d_write_i  input  1  exec-stage store request.
REQ-010 SHALL have d_strb_i  input  4  store byte strobes.
REQ-011 SHALL have d_addr_i  input  32  data word address.
REQ-012 SHALL have d_wdata_i  input  32  store data.
REQ-013 SHALL have d_gnt_o  output  1  one-cycle pulse: data request captured.
REQ-014 SHALL have d_rvalid_o  output  1  one-cycle pulse: rdata_o holds load data, or store accepted.
REQ-015 SHALL have rdata_o  output  32  read data, shared by both requesters.
REQ-016 SHALL have mem_req_o  output  1  memory request.
REQ-017 SHALL have mem_we_o  output  1  1 = write.
REQ-018 SHALL have mem_strb_o  output  4  write strobes; 4'b1111 for reads.
REQ-019 SHALL have mem_addr_o  output  32  memory address.
REQ-020 SHALL have mem_wdata_o  output  32  write data.
REQ-021 SHALL have mem_gnt_i  input  1  memory accepted mem_req_o this cycle.
REQ-022 SHALL have mem_rvalid_i  input  1  read data valid on mem_rdata_i.
REQ-023 SHALL have mem_rdata_i  input  32  memory read data.

Function
REQ-024 SHALL implement FSM IDLE, REQ, WAIT_R; exactly one transaction outstanding.
REQ-025 IDLE: if any request, latch winner's address/we/strb/wdata, pulse its gnt the same cycle, go to REQ next cycle; otherwise stay in IDLE.
REQ-026 REQ: drive mem_req_o=1 with latched payload; on mem_gnt_i a store goes to IDLE and pulses d_rvalid_o the next cycle; a load goes to WAIT_R.
REQ-027 WAIT_R: on mem_rvalid_i register mem_rdata_i to rdata_o, pulse owner's rvalid next cycle, and go to IDLE; mem_rvalid_i outside WAIT_R SHALL be ignored.
REQ-028 Minimum latency: read request to rvalid is 3 cycles with gnt and rvalid each returned one cycle after being requested; store request to d_rvalid_o is 2 cycles with immediate gnt.
REQ-029 Fixed priority: data wins a simultaneous request unless the starve counter equals STARVE_LIMIT, in which case fetch wins.
REQ-030 Starve counter SHALL increment on each data grant while if_req_i=1, clear on any fetch grant, and saturate at STARVE_LIMIT.
REQ-031 d_read_i and d_write_i both high SHALL be treated as a store.
REQ-032 rdata_o SHALL hold its value until the next read completes.
REQ-033 Requests arriving in REQ or WAIT_R SHALL wait; gnt is never given outside IDLE.

Reset
REQ-034 rst_ni low SHALL force IDLE, clear the starve counter and RR pointer, and drive all outputs to 0, including rdata_o and mem_*.
REQ-035 Reset mid-transaction SHALL abandon it with no rvalid pulse; late mem_rvalid_i is ignored.

Configuration
REQ-036 Macro MEM_ARB_RR_EN defined: simultaneous requests SHALL alternate by round-robin pointer toggled on each grant, and STARVE_LIMIT is unused.
REQ-037 Macro MEM_ARB_RR_EN undefined: fixed priority with starve counter per REQ-029 and REQ-030.

Verification
REQ-038 Fetch-only read: addr 0x100, gnt after 1 cycle, rvalid with 0xDEADBEEF -> if_rvalid_o pulses one cycle, rdata_o=0xDEADBEEF.
REQ-039 Store: addr 0x40, strb 4'b0011, wdata 0x1234 -> mem_we_o=1, mem_strb_o=4'b0011 in REQ, d_rvalid_o pulses, no if_* pulses.
REQ-040 Continuous fetch and load requests, fixed priority, STARVE_LIMIT=4 -> 4 data grants, then 1 fetch grant, repeating.
REQ-041 Same stimulus with MEM_ARB_RR_EN -> grants alternate data, fetch, data, fetch.
REQ-042 rst_ni low during WAIT_R, then mem_rvalid_i -> no rvalid pulse, FSM in IDLE, all outputs 0.
REQ-043 mem_gnt_i held low for 5 cycles -> mem_req_o and payload stable for all 5 cycles; new requests not granted.
